compare_scoreboard: RTL and testbench
=====================================

Name: compare_scoreboard

Overview:
- Synthesizable result-checking stage that sits directly downstream of the DUT/reference pair.
- Each cycle it consumes a reference output and a DUT output and compares them.
- Accumulates sample and mismatch statistics over a run, records the first mismatch, and applies a run timeout.
- Presents a final report through a valid/ready handshake, so gate-level blocks such as the AND-gate problem can be self-checked in hardware or emulation.

Parameters:
- WIDTH, 1, bit width of the compared output vector (1 for single-output gates).
- CNT_W, 32, width of all statistics counters.
- TIMEOUT, 100000, RUN-state cycle limit before a forced report.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous active-high reset.
- start  in  1  begin a run (IDLE or REPORT-done only).
- stop  in  1  end the run; move to REPORT.
- sample_valid  in  1  ref_val/dut_val are a sample this cycle.
- ref_val  in  WIDTH  reference output.
- dut_val  in  WIDTH  DUT output.
- busy  out  1  high in RUN.
- samples  out  CNT_W  count of valid samples this run.
- errors  out  CNT_W  count of mismatched samples.
- first_err_idx  out  CNT_W  0-based sample index of the first mismatch.
- first_err_bits  out  WIDTH  ref_val XOR dut_val at the first mismatch.
- any_error  out  1  sticky: at least one mismatch this run.
- timeout  out  1  run ended by TIMEOUT, not by stop.
- report_valid  out  1  report fields are final.
- report_ready  in  1  consumer accepts the report.

Behaviour:
- Reset (async assert, sync-released usage): state IDLE; all outputs and internal cycle counter 0.
- States:
  - IDLE: start goes to RUN. Entering RUN clears samples, errors, first_err_idx, first_err_bits, any_error, timeout, and the cycle counter in the same edge. The start-cycle sample is not counted.
  - RUN: busy=1.
    - If sample_valid, samples increments.
    - If sample_valid and ref_val != dut_val, errors increments.
    - If that mismatch is also the first (any_error==0): first_err_idx <= current samples value (pre-increment), first_err_bits <= ref_val^dut_val, any_error <= 1.
    - The cycle counter increments every RUN cycle.
    - stop goes to REPORT. A sample presented in the stop cycle is counted.
    - Cycle counter == TIMEOUT-1 without stop goes to REPORT with timeout<=1. That cycle's sample is also counted.
    - start in RUN is ignored.
  - REPORT: report_valid=1; all statistics frozen; sample_valid ignored. report_valid&&report_ready goes to IDLE; report_valid low from the next cycle. Fields hold their values in IDLE until the next start.
- Counters saturate at all-ones (no wrap). errors can never exceed samples.
- Comparison is bitwise over the full WIDTH. Any differing bit is one mismatch, counted once per sample.
- Latency: statistics reflect a sample on the edge following its presentation. report_valid asserts 1 cycle after the stop cycle.
- areset mid-run aborts the run immediately: IDLE, all zero, no report.
- stop in IDLE or REPORT is ignored. start and stop together in IDLE: start wins; stop is evaluated from the next cycle.

Decomposition:
- Package compare_scoreboard_pkg holds:
  - state enum {IDLE, RUN, REPORT}.
  - default CNT_W and TIMEOUT constants.
- One sub-module, sat_counter (parameter W; inputs clr, inc; output q), saturating at all-ones. Instantiated for samples, errors, and the cycle counter.

Test Plan:
- Matching run: WIDTH=1, start, then 10 cycles with sample_valid=1 and ref_val=dut_val=a&b over all four a,b combinations, then stop. Required: samples=10, errors=0, any_error=0, timeout=0; report_valid one cycle after stop.
- First-mismatch capture: 20 samples, dut inverted at sample indices 5 and 12. Required: errors=2, first_err_idx=5, first_err_bits=1, any_error=1.
- Timeout: TIMEOUT=50, start, continuous samples, never stop. Required: REPORT entered after 50 RUN cycles, samples=50, timeout=1, busy=0.
- Handshake and hold: hold report_ready=0 for 7 cycles. Required: report_valid stays 1 and fields stay stable. Then report_ready=1 for one cycle: IDLE, report_valid=0, fields unchanged until the next start; the next start clears them to 0.
- Saturation: CNT_W=4, 20 mismatching samples. Required: samples=15, errors=15, no wrap.
- Reset mid-run: assert areset after 6 samples with 2 errors. Required: all outputs 0 asynchronously; a new start begins a clean run.

Source files
------------

// File: rtl/compare_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// compare_scoreboard_pkg
// Shared types and defaults for the compare_scoreboard result checker.
//   state_t      : run-control states (IDLE, RUN, REPORT)
//   DEF_CNT_W    : default width of the statistics counters
//   DEF_TIMEOUT  : default RUN-state cycle limit before a forced report
// -----------------------------------------------------------------------------
package compare_scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 100000;

endpackage

// File: rtl/compare_scoreboard_if.sv
// -----------------------------------------------------------------------------
// compare_scoreboard_if
// Bundles the run control, sample stream and report handshake of the
// scoreboard.
//   master modport : drives start/stop, samples and report_ready; reads report
//   slave modport  : the scoreboard side (inverse directions)
// Signals:
//   start, stop           run control
//   sample_valid          ref_val/dut_val carry a sample this cycle
//   ref_val, dut_val      WIDTH-bit reference and DUT outputs
//   busy                  high while a run is in progress
//   samples, errors       CNT_W-bit statistics
//   first_err_idx         sample index of the first mismatch
//   first_err_bits        ref_val ^ dut_val at the first mismatch
//   any_error, timeout    sticky flags
//   report_valid/ready    final-report handshake
// -----------------------------------------------------------------------------
interface compare_scoreboard_if
  import compare_scoreboard_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             stop;
  logic             sample_valid;
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] dut_val;
  logic             busy;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_bits;
  logic             any_error;
  logic             timeout;
  logic             report_valid;
  logic             report_ready;

  modport master (
    output start, stop, sample_valid, ref_val, dut_val, report_ready,
    input  busy, samples, errors, first_err_idx, first_err_bits,
           any_error, timeout, report_valid
  );

  modport slave (
    input  start, stop, sample_valid, ref_val, dut_val, report_ready,
    output busy, samples, errors, first_err_idx, first_err_bits,
           any_error, timeout, report_valid
  );

endinterface

// File: rtl/compare_scoreboard_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, areset : clock, asynchronous active-high reset (q -> 0)
//   clr         : synchronous clear, higher priority than inc
//   inc         : count up by one unless already all-ones
//   q           : W-bit count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/compare_scoreboard.sv
// -----------------------------------------------------------------------------
// compare_scoreboard
// Compares a reference output against a DUT output every cycle of a run,
// accumulates sample/mismatch statistics, captures the first mismatch and
// enforces a run timeout. The final report is offered on a valid/ready
// handshake and held until the next run starts.
//   clk    : rising-edge clock
//   areset : asynchronous active-high reset, aborts any run
//   bus    : compare_scoreboard_if.slave (control, samples, report)
// Parameters: WIDTH (compared vector), CNT_W (counters), TIMEOUT (RUN cycles)
// -----------------------------------------------------------------------------
module compare_scoreboard
  import compare_scoreboard_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 areset,
  compare_scoreboard_if.slave  bus
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits; the cycle counter never
  // needs to go further because the run ends when it reaches that value.
  localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_reg, state_next;
  logic             busy_next, report_valid_next;
  logic             run_enter, in_run, sample_take, mismatch, cyc_limit;
  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] samples_q, errors_q, first_idx_reg;
  logic [WIDTH-1:0] first_bits_reg;
  logic             any_error_reg, timeout_reg;
  logic [CYC_W-1:0] cyc_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
    assign diff[gi] = bus.ref_val[gi] ^ bus.dut_val[gi];
  end

  // start is only honoured from IDLE; in the same cycle stop is not looked at.
  assign run_enter   = (state_reg == IDLE) && bus.start;
  assign in_run      = (state_reg == RUN);
  assign sample_take = in_run && bus.sample_valid;
  // Any differing bit makes the whole sample a single mismatch.
  assign mismatch    = sample_take && (|diff);
  assign cyc_limit   = (cyc_q == CYC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    busy_next         = 1'b0;
    report_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        busy_next = 1'b1;
        if (bus.stop || cyc_limit) state_next = REPORT;
      end
      REPORT: begin
        report_valid_next = 1'b1;
        if (bus.report_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Errors only ever increment alongside samples, so errors <= samples holds
  // even once both have saturated.
  sat_counter #(.W(CNT_W)) u_samples (
    .clk(clk), .areset(areset), .clr(run_enter), .inc(sample_take), .q(samples_q)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk(clk), .areset(areset), .clr(run_enter), .inc(mismatch), .q(errors_q)
  );

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk(clk), .areset(areset), .clr(run_enter), .inc(in_run), .q(cyc_q)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      first_idx_reg  <= '0;
      first_bits_reg <= '0;
      any_error_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
    end else if (run_enter) begin
      first_idx_reg  <= '0;
      first_bits_reg <= '0;
      any_error_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
    end else if (in_run) begin
      // The index is the sample count before this sample is added.
      if (mismatch && !any_error_reg) begin
        first_idx_reg  <= samples_q;
        first_bits_reg <= diff;
        any_error_reg  <= 1'b1;
      end
      // A stop in the limit cycle counts as a normal end, not a timeout.
      if (cyc_limit && !bus.stop) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.busy           = busy_next;
  assign bus.report_valid   = report_valid_next;
  assign bus.samples        = samples_q;
  assign bus.errors         = errors_q;
  assign bus.first_err_idx  = first_idx_reg;
  assign bus.first_err_bits = first_bits_reg;
  assign bus.any_error      = any_error_reg;
  assign bus.timeout        = timeout_reg;

endmodule

// File: tb/tb_compare_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_compare_scoreboard
// Two scoreboard instances: A (WIDTH=1, CNT_W=32, TIMEOUT=50) for the gate
// style scenarios and timeout, B (WIDTH=4, CNT_W=4, TIMEOUT=100) for
// saturation and multi-bit random runs. Expected report fields come from a
// run-level model that walks the queued stimulus with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_compare_scoreboard;

  localparam int A_W = 1, A_CW = 32, A_TO = 50;
  localparam int B_W = 4, B_CW = 4,  B_TO = 100;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  compare_scoreboard_if #(.WIDTH(A_W), .CNT_W(A_CW)) ia ();
  compare_scoreboard_if #(.WIDTH(B_W), .CNT_W(B_CW)) ib ();

  compare_scoreboard #(.WIDTH(A_W), .CNT_W(A_CW), .TIMEOUT(A_TO)) dut_a (
    .clk(clk), .areset(areset), .bus(ia)
  );
  compare_scoreboard #(.WIDTH(B_W), .CNT_W(B_CW), .TIMEOUT(B_TO)) dut_b (
    .clk(clk), .areset(areset), .bus(ib)
  );

  int errs = 0;
  int checks = 0;

  // Stimulus of the run under test, one entry per RUN cycle.
  bit         q_vld[$];
  logic [3:0] q_ref[$];
  logic [3:0] q_dut[$];

  // Expected report from the model.
  logic [31:0] e_samples, e_errors, e_idx;
  logic [3:0]  e_bits;
  logic        e_any, e_to;

  logic rv_before_last, busy_before_last;
  logic [98:0] got_a, exp_a;
  logic [17:0] got_b, exp_b;

  // Run-level model: walk the cycles the run actually lasts (until stop or
  // the timeout limit) and count with saturating arithmetic.
  function automatic void model(input int stop_at, input int to, input logic [31:0] cmax);
    int ncyc;
    logic [31:0] s, e;
    ncyc  = (stop_at >= 0 && stop_at < to) ? stop_at + 1 : to;
    e_to  = !(stop_at >= 0 && stop_at < to);
    s = 0; e = 0; e_idx = 0; e_bits = 0; e_any = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (q_vld[i]) begin
        if (q_ref[i] != q_dut[i]) begin
          if (!e_any) begin
            e_any  = 1'b1;
            e_idx  = s;
            e_bits = q_ref[i] ^ q_dut[i];
          end
          if (e < cmax) e = e + 1;
        end
        if (s < cmax) s = s + 1;
      end
    end
    e_samples = s;
    e_errors  = e;
  endfunction

  function automatic logic [98:0] rep_a();
    return {ia.samples, ia.errors, ia.first_err_idx, ia.first_err_bits, ia.any_error, ia.timeout};
  endfunction
  function automatic logic [98:0] exp_rep_a();
    return {e_samples, e_errors, e_idx, e_bits[0], e_any, e_to};
  endfunction
  function automatic logic [17:0] rep_b();
    return {ib.samples, ib.errors, ib.first_err_idx, ib.first_err_bits, ib.any_error, ib.timeout};
  endfunction
  function automatic logic [17:0] exp_rep_b();
    return {e_samples[3:0], e_errors[3:0], e_idx[3:0], e_bits, e_any, e_to};
  endfunction

  task automatic fill_random(input int n, input logic [3:0] mask, input int vld_pct, input int err_pct);
    logic [3:0] r, flip;
    q_vld.delete(); q_ref.delete(); q_dut.delete();
    for (int i = 0; i < n; i++) begin
      r = 4'($urandom) & mask;
      q_vld.push_back($urandom_range(99) < vld_pct);
      q_ref.push_back(r);
      if ($urandom_range(99) < err_pct) begin
        do flip = 4'($urandom) & mask; while (flip == 4'h0);
        q_dut.push_back(r ^ flip);
      end else begin
        q_dut.push_back(r);
      end
    end
  endtask

  task automatic drive(input bit use_b, input logic st, sp, sv, input logic [3:0] r, d, input logic rr);
    if (use_b) begin
      ib.start = st; ib.stop = sp; ib.sample_valid = sv;
      ib.ref_val = r; ib.dut_val = d; ib.report_ready = rr;
    end else begin
      ia.start = st; ia.stop = sp; ia.sample_valid = sv;
      ia.ref_val = r[0]; ia.dut_val = d[0]; ia.report_ready = rr;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start cycle carries a mismatching sample that must not be counted; stray
  // start pulses inside the run must be ignored.
  task automatic drive_run(input bit use_b, input int ncyc, input int stop_at, input bit start_stop);
    drive(use_b, 1'b1, start_stop, 1'b1, 4'h0, 4'hF, 1'b0);
    step();
    for (int i = 0; i < ncyc; i++) begin
      drive(use_b, ($urandom_range(3) == 0), (i == stop_at), q_vld[i], q_ref[i], q_dut[i], 1'b0);
      rv_before_last   = use_b ? ib.report_valid : ia.report_valid;
      busy_before_last = use_b ? ib.busy : ia.busy;
      step();
    end
    drive(use_b, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic ack(input bit use_b);
    drive(use_b, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step();
    drive(use_b, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(); step();
    got_a = rep_a();
    if (got_a !== '0) begin errs++; $display("FAIL reset_fields_a: got %h expected 0", got_a); end
    checks++;
    got_b = rep_b();
    if (got_b !== '0) begin errs++; $display("FAIL reset_fields_b: got %h expected 0", got_b); end
    checks++;
    areset = 1'b0;
    step();
    if ({ia.busy, ia.report_valid, ib.busy, ib.report_valid} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 0000", {ia.busy, ia.report_valid, ib.busy, ib.report_valid});
    end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_matching();
    logic a, b;
    q_vld.delete(); q_ref.delete(); q_dut.delete();
    for (int i = 0; i < 10; i++) begin
      a = (i % 2) == 1;
      b = ((i / 2) % 2) == 1;
      q_vld.push_back(1'b1); q_ref.push_back({3'b000, a & b}); q_dut.push_back({3'b000, a & b});
    end
    q_vld.push_back(1'b0); q_ref.push_back(4'h0); q_dut.push_back(4'h0);
    model(10, A_TO, 32'hFFFF_FFFF);
    drive_run(1'b0, 11, 10, 1'b0);
    if (rv_before_last !== 1'b0) begin errs++; $display("FAIL match_rv_early: got %b expected 0", rv_before_last); end
    checks++;
    if ({ia.report_valid, ia.busy} !== 2'b10) begin errs++; $display("FAIL match_rv_after_stop: got %b expected 10", {ia.report_valid, ia.busy}); end
    checks++;
    got_a = rep_a(); exp_a = exp_rep_a();
    if (got_a !== exp_a) begin errs++; $display("FAIL match_fields: got %h expected %h", got_a, exp_a); end
    checks++;
    if (ia.samples !== 32'd10) begin errs++; $display("FAIL match_samples: got %0d expected 10", ia.samples); end
    checks++;
    ack(1'b0);
    if (ia.report_valid !== 1'b0) begin errs++; $display("FAIL match_ack: got %b expected 0", ia.report_valid); end
    checks++;
    $display("test_matching done: samples=%0d errors=%0d", ia.samples, ia.errors);
  endtask

  task automatic test_first_mismatch();
    logic r;
    q_vld.delete(); q_ref.delete(); q_dut.delete();
    for (int i = 0; i < 20; i++) begin
      r = 1'($urandom);
      q_vld.push_back(1'b1); q_ref.push_back({3'b000, r});
      q_dut.push_back({3'b000, (i == 5 || i == 12) ? ~r : r});
    end
    model(19, A_TO, 32'hFFFF_FFFF);
    drive_run(1'b0, 20, 19, 1'b0);
    got_a = rep_a(); exp_a = exp_rep_a();
    if (got_a !== exp_a) begin errs++; $display("FAIL first_fields: got %h expected %h", got_a, exp_a); end
    checks++;
    if ({ia.errors, ia.first_err_idx, ia.first_err_bits, ia.any_error} !== {32'd2, 32'd5, 1'b1, 1'b1}) begin
      errs++; $display("FAIL first_capture: got errors=%0d idx=%0d bits=%b any=%b expected 2 5 1 1",
                       ia.errors, ia.first_err_idx, ia.first_err_bits, ia.any_error);
    end
    checks++;
    $display("test_first_mismatch done: idx=%0d", ia.first_err_idx);
  endtask

  // Continues from the REPORT state left by test_first_mismatch.
  task automatic test_handshake_hold();
    exp_a = exp_rep_a();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      step();
      got_a = rep_a();
      if (ia.report_valid !== 1'b1 || got_a !== exp_a) begin
        errs++; $display("FAIL hold_cycle%0d: got rv=%b %h expected rv=1 %h", k, ia.report_valid, got_a, exp_a);
      end
      checks++;
    end
    ack(1'b0);
    got_a = rep_a();
    if ({ia.report_valid, ia.busy} !== 2'b00 || got_a !== exp_a) begin
      errs++; $display("FAIL hold_after_ack: got rv/busy=%b %h expected 00 %h", {ia.report_valid, ia.busy}, got_a, exp_a);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'($urandom), 1'b1, 4'($urandom), 4'($urandom), 1'b0);
      step();
    end
    got_a = rep_a();
    if (got_a !== exp_a) begin errs++; $display("FAIL hold_idle: got %h expected %h", got_a, exp_a); end
    checks++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    got_a = rep_a();
    if (got_a !== '0 || ia.busy !== 1'b1) begin
      errs++; $display("FAIL hold_restart_clear: got busy=%b %h expected 1 0", ia.busy, got_a);
    end
    checks++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step();
    ack(1'b0);
    $display("test_handshake_hold done");
  endtask

  task automatic test_timeout();
    fill_random(A_TO + 5, 4'h1, 100, 30);
    model(-1, A_TO, 32'hFFFF_FFFF);
    drive_run(1'b0, A_TO, -1, 1'b0);
    if (busy_before_last !== 1'b1) begin errs++; $display("FAIL timeout_early: got busy=%b expected 1", busy_before_last); end
    checks++;
    if ({ia.busy, ia.report_valid, ia.timeout} !== 3'b011) begin
      errs++; $display("FAIL timeout_state: got busy/rv/to=%b expected 011", {ia.busy, ia.report_valid, ia.timeout});
    end
    checks++;
    got_a = rep_a(); exp_a = exp_rep_a();
    if (got_a !== exp_a || ia.samples !== 32'd50) begin
      errs++; $display("FAIL timeout_fields: got %h expected %h", got_a, exp_a);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0);
      step();
    end
    got_a = rep_a();
    if (got_a !== exp_a) begin errs++; $display("FAIL timeout_frozen: got %h expected %h", got_a, exp_a); end
    checks++;
    ack(1'b0);
    $display("test_timeout done: samples=%0d", ia.samples);
  endtask

  task automatic test_saturation();
    fill_random(20, 4'hF, 100, 100);
    model(19, B_TO, 32'd15);
    drive_run(1'b1, 20, 19, 1'b0);
    got_b = rep_b(); exp_b = exp_rep_b();
    if (got_b !== exp_b) begin errs++; $display("FAIL sat_fields: got %h expected %h", got_b, exp_b); end
    checks++;
    if ({ib.samples, ib.errors} !== 8'hFF) begin
      errs++; $display("FAIL sat_counts: got samples=%0d errors=%0d expected 15 15", ib.samples, ib.errors);
    end
    checks++;
    ack(1'b1);
    $display("test_saturation done");
  endtask

  task automatic test_back_to_back();
    int n;
    bit ss;
    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 20);
      ss = 1'($urandom);
      fill_random(n, 4'hF, 70, 30);
      model(n - 1, B_TO, 32'd15);
      drive_run(1'b1, n, n - 1, ss);
      got_b = rep_b(); exp_b = exp_rep_b();
      if (got_b !== exp_b || ib.report_valid !== 1'b1) begin
        errs++; $display("FAIL b2b_run%0d: got rv=%b %h expected rv=1 %h", r, ib.report_valid, got_b, exp_b);
      end
      checks++;
      ack(1'b1);
      $display("b2b run %0d: n=%0d samples=%0d errors=%0d", r, n, ib.samples, ib.errors);
    end
  endtask

  task automatic test_reset_midrun();
    q_vld.delete(); q_ref.delete(); q_dut.delete();
    for (int i = 0; i < 6; i++) begin
      q_vld.push_back(1'b1); q_ref.push_back(4'h1);
      q_dut.push_back((i == 1 || i == 4) ? 4'h0 : 4'h1);
    end
    drive_run(1'b0, 6, -1, 1'b0);
    if ({ia.busy, ia.samples, ia.errors} !== {1'b1, 32'd6, 32'd2}) begin
      errs++; $display("FAIL midrun_pre: got busy=%b samples=%0d errors=%0d expected 1 6 2", ia.busy, ia.samples, ia.errors);
    end
    checks++;
    #2 areset = 1'b1;
    #1;
    got_a = rep_a();
    if (got_a !== '0 || {ia.busy, ia.report_valid} !== 2'b00) begin
      errs++; $display("FAIL midrun_async_clear: got busy/rv=%b %h expected 00 0", {ia.busy, ia.report_valid}, got_a);
    end
    checks++;
    @(posedge clk); #1;
    areset = 1'b0;
    step();
    fill_random(8, 4'h1, 80, 40);
    model(7, A_TO, 32'hFFFF_FFFF);
    drive_run(1'b0, 8, 7, 1'b0);
    got_a = rep_a(); exp_a = exp_rep_a();
    if (got_a !== exp_a) begin errs++; $display("FAIL midrun_clean_run: got %h expected %h", got_a, exp_a); end
    checks++;
    ack(1'b0);
    $display("test_reset_midrun done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_matching();
    test_first_mismatch();
    test_handshake_hold();
    test_timeout();
    test_saturation();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
